// File: rtl/y86_mem_stage_pkg.sv
// Shared Y86 constants and memory-stage types for the M/W slice of the pipeline.
package y86_mem_stage_pkg;

  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RMMOVL = 4'h4;
  localparam logic [3:0] I_MRMOVL = 4'h5;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHL  = 4'hA;
  localparam logic [3:0] I_POPL   = 4'hB;

  localparam logic [3:0] S_OK  = 4'h1;
  localparam logic [3:0] S_ADR = 4'h3;

  localparam logic [3:0] R_NONE = 4'hF;

  typedef enum logic [1:0] {
    MS_IDLE = 2'd0,
    MS_REQ  = 2'd1,
    MS_DONE = 2'd2
  } mstate_e;

endpackage

// File: rtl/y86_mem_stage_regW.sv
// W pipeline register: synchronous active-low reset, bubble beats stall.
module y86_regW
  import y86_mem_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        bubble,
  input  logic [3:0]  stat,
  input  logic [3:0]  icode,
  input  logic [31:0] val_e,
  input  logic [31:0] val_m,
  input  logic [3:0]  dst_e,
  input  logic [3:0]  dst_m,
  output logic [3:0]  w_stat,
  output logic [3:0]  w_icode,
  output logic [31:0] w_val_e,
  output logic [31:0] w_val_m,
  output logic [3:0]  w_dst_e,
  output logic [3:0]  w_dst_m
);

  always_ff @(posedge clk) begin
    if (!reset || bubble) begin
      w_stat  <= S_OK;
      w_icode <= I_NOP;
      w_val_e <= '0;
      w_val_m <= '0;
      w_dst_e <= R_NONE;
      w_dst_m <= R_NONE;
    end else if (!stall) begin
      w_stat  <= stat;
      w_icode <= icode;
      w_val_e <= val_e;
      w_val_m <= val_m;
      w_dst_e <= dst_e;
      w_dst_m <= dst_m;
    end
  end

endmodule

// File: rtl/y86_mem_stage.sv
// Y86 memory stage: req/ack data-memory access FSM with timeout, status and W register.
module y86_mem_stage
  import y86_mem_stage_pkg::*;
#(
  parameter logic [31:0] MEM_BYTES = 32'h0000_1000,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  M_stat,
  input  logic [3:0]  M_icode,
  input  logic [3:0]  M_dstE,
  input  logic [3:0]  M_dstM,
  input  logic [31:0] M_valE,
  input  logic [31:0] M_valA,
  input  logic        W_stall,
  input  logic        W_bubble,
  input  logic        dmem_ack,
  input  logic        dmem_err,
  input  logic [31:0] dmem_rdata,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic        m_busy,
  output logic [3:0]  m_stat,
  output logic [31:0] m_valM,
  output logic [3:0]  Wout_stat,
  output logic [3:0]  Wout_icode,
  output logic [3:0]  Wout_dstE,
  output logic [3:0]  Wout_dstM,
  output logic [31:0] Wout_valE,
  output logic [31:0] Wout_valM
);

  // Counter preloads TIMEOUT-1 so REQ lasts at most TIMEOUT cycles.
  localparam logic [15:0] CNT_LOAD = (TIMEOUT == 0) ? '0 : 16'(TIMEOUT - 1);

  mstate_e     state, state_n;
  logic [15:0] cnt, cnt_n;
  logic [31:0] hold_valM, hold_valM_n;
  logic        hold_err, hold_err_n;
  logic        is_rd, is_wr, need_mem, range_err, w_bubble;
  logic [31:0] addr;
  logic [3:0]  w_dstE, w_dstM;

  always_comb begin
    is_rd     = M_icode inside {I_MRMOVL, I_POPL, I_RET};
    is_wr     = M_icode inside {I_RMMOVL, I_PUSHL, I_CALL};
    addr      = (M_icode == I_POPL || M_icode == I_RET) ? M_valA : M_valE;
    need_mem  = (is_rd || is_wr) && (M_stat == S_OK);
    range_err = need_mem && (addr > (MEM_BYTES - 32'd4));
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= MS_IDLE;
      cnt       <= '0;
      hold_valM <= '0;
      hold_err  <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      hold_valM <= hold_valM_n;
      hold_err  <= hold_err_n;
    end
  end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    hold_valM_n = hold_valM;
    hold_err_n  = hold_err;
    case (state)
      MS_IDLE: begin
        if (need_mem && !range_err) begin
          state_n = MS_REQ;
          cnt_n   = CNT_LOAD;
        end
      end
      MS_REQ: begin
        if (dmem_ack) begin
          hold_valM_n = dmem_rdata;
          hold_err_n  = dmem_err;
          state_n     = MS_DONE;
        end else if (TIMEOUT != 0 && cnt == '0) begin
          hold_valM_n = '0;
          hold_err_n  = 1'b1;
          state_n     = MS_DONE;
        end else if (cnt != '0) begin
          cnt_n = cnt - 16'd1;
        end
      end
      MS_DONE: begin
        if (!W_stall) state_n = MS_IDLE;
      end
      default: state_n = MS_IDLE;
    endcase
  end

  always_comb begin
    dmem_req   = (state == MS_REQ);
    dmem_we    = dmem_req && is_wr;
    dmem_addr  = dmem_req ? addr : '0;
    dmem_wdata = dmem_req ? M_valA : '0;
    m_busy     = ((state == MS_IDLE) && need_mem && !range_err) || (state == MS_REQ);
    m_valM     = (state == MS_DONE) ? hold_valM : '0;
    m_stat     = (range_err || ((state == MS_DONE) && hold_err)) ? S_ADR : M_stat;
    w_dstE     = (m_stat == S_ADR) ? R_NONE : M_dstE;
    w_dstM     = (m_stat == S_ADR) ? R_NONE : M_dstM;
    // Stall outranks the self-bubble; an external bubble outranks both.
    w_bubble   = W_bubble || (!W_stall && m_busy);
  end

  y86_regW u_regW (
    .clk     (clk),
    .reset   (reset),
    .stall   (W_stall),
    .bubble  (w_bubble),
    .stat    (m_stat),
    .icode   (M_icode),
    .val_e   (M_valE),
    .val_m   (m_valM),
    .dst_e   (w_dstE),
    .dst_m   (w_dstM),
    .w_stat  (Wout_stat),
    .w_icode (Wout_icode),
    .w_val_e (Wout_valE),
    .w_val_m (Wout_valM),
    .w_dst_e (Wout_dstE),
    .w_dst_m (Wout_dstM)
  );

endmodule

// File: tb/tb_y86_mem_stage.sv
// Self-checking bench for y86_mem_stage: directed cases then randomized instructions vs a transaction model.
module tb_y86_mem_stage;

  localparam logic [31:0] MEMB = 32'h0000_1000;
  localparam int unsigned TMO  = 16;

  localparam logic [3:0] C_NOP = 4'h1, C_RMMOVL = 4'h4, C_MRMOVL = 4'h5, C_OPL = 4'h6;
  localparam logic [3:0] C_CALL = 4'h8, C_RET = 4'h9, C_PUSHL = 4'hA, C_POPL = 4'hB;
  localparam logic [3:0] ST_OK = 4'h1, ST_HLT = 4'h2, ST_ADR = 4'h3, ST_INS = 4'h4;
  localparam logic [3:0] RNONE = 4'hF;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  M_stat, M_icode, M_dstE, M_dstM;
  logic [31:0] M_valE, M_valA;
  logic        W_stall, W_bubble;
  logic        dmem_ack, dmem_err;
  logic [31:0] dmem_rdata;
  logic        dmem_req, dmem_we, m_busy;
  logic [31:0] dmem_addr, dmem_wdata, m_valM;
  logic [3:0]  m_stat;
  logic [3:0]  Wout_stat, Wout_icode, Wout_dstE, Wout_dstM;
  logic [31:0] Wout_valE, Wout_valM;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  y86_mem_stage #(.MEM_BYTES(MEMB), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .M_stat(M_stat), .M_icode(M_icode), .M_dstE(M_dstE), .M_dstM(M_dstM),
    .M_valE(M_valE), .M_valA(M_valA),
    .W_stall(W_stall), .W_bubble(W_bubble),
    .dmem_ack(dmem_ack), .dmem_err(dmem_err), .dmem_rdata(dmem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .m_busy(m_busy), .m_stat(m_stat), .m_valM(m_valM),
    .Wout_stat(Wout_stat), .Wout_icode(Wout_icode), .Wout_dstE(Wout_dstE), .Wout_dstM(Wout_dstM),
    .Wout_valE(Wout_valE), .Wout_valM(Wout_valM)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_w(input string tag, input logic [3:0] st, input logic [3:0] ic,
                         input logic [31:0] ve, input logic [31:0] vm, input logic chk_vm,
                         input logic [3:0] de, input logic [3:0] dm);
    chk({tag, ".Wstat"},  32'(Wout_stat),  32'(st));
    chk({tag, ".Wicode"}, 32'(Wout_icode), 32'(ic));
    chk({tag, ".WvalE"},  Wout_valE, ve);
    if (chk_vm) chk({tag, ".WvalM"}, Wout_valM, vm);
    chk({tag, ".WdstE"},  32'(Wout_dstE),  32'(de));
    chk({tag, ".WdstM"},  32'(Wout_dstM),  32'(dm));
  endtask

  task automatic check_w_bubble(input string tag);
    check_w(tag, ST_OK, C_NOP, 32'd0, 32'd0, 1'b1, RNONE, RNONE);
  endtask

  // Model: one instruction's life in M, from the transaction-level rules.
  task automatic run_instr(input string tag, input logic [3:0] icode, input logic [3:0] st,
                           input logic [31:0] valE, input logic [31:0] valA,
                           input logic [3:0] dE, input logic [3:0] dM,
                           input int unsigned ack_lat, input logic err,
                           input logic [31:0] rdata, input int unsigned stalls);
    logic rd, wr, need, rerr, tmo, err_eff;
    logic [31:0] addr;
    logic [3:0] es;
    int unsigned nreq;
    rd   = (icode == C_MRMOVL) || (icode == C_POPL) || (icode == C_RET);
    wr   = (icode == C_RMMOVL) || (icode == C_PUSHL) || (icode == C_CALL);
    addr = (icode == C_POPL || icode == C_RET) ? valA : valE;
    need = (rd || wr) && (st == ST_OK);
    rerr = need && (addr > MEMB - 4);
    M_icode = icode; M_stat = st; M_valE = valE; M_valA = valA; M_dstE = dE; M_dstM = dM;
    W_stall = 1'b0; W_bubble = 1'b0;
    dmem_ack = 1'($urandom_range(0, 1)); dmem_err = 1'($urandom_range(0, 1)); dmem_rdata = $urandom;
    #1;
    chk({tag, ".busy0"}, 32'(m_busy), 32'(need && !rerr));
    chk({tag, ".req0"}, 32'(dmem_req), 32'd0);
    if (!need || rerr) begin
      es = rerr ? ST_ADR : st;
      chk({tag, ".mstat"}, 32'(m_stat), 32'(es));
      chk({tag, ".mvalM"}, m_valM, 32'd0);
      @(posedge clk); #1;
      check_w(tag, es, icode, valE, 32'd0, 1'b1, (es == ST_ADR) ? RNONE : dE, (es == ST_ADR) ? RNONE : dM);
      return;
    end
    @(posedge clk); #1;
    check_w_bubble({tag, ".idle"});
    tmo  = (ack_lat == 0) || (ack_lat > TMO);
    nreq = tmo ? TMO : ack_lat;
    for (int unsigned c = 1; c <= nreq; c++) begin
      dmem_ack   = !tmo && (c == nreq);
      dmem_rdata = dmem_ack ? rdata : $urandom;
      dmem_err   = dmem_ack ? err : 1'($urandom_range(0, 1));
      #1;
      chk({tag, ".busyR"}, 32'(m_busy), 32'd1);
      chk({tag, ".req"},   32'(dmem_req), 32'd1);
      chk({tag, ".we"},    32'(dmem_we), 32'(wr));
      chk({tag, ".addr"},  dmem_addr, addr);
      chk({tag, ".wdata"}, dmem_wdata, valA);
      @(posedge clk); #1;
      check_w_bubble({tag, ".req"});
    end
    err_eff = tmo || err;
    es = err_eff ? ST_ADR : ST_OK;
    for (int unsigned s = 0; s <= stalls; s++) begin
      W_stall    = (s < stalls);
      dmem_ack   = 1'b1;
      dmem_err   = 1'($urandom_range(0, 1));
      dmem_rdata = $urandom;
      #1;
      chk({tag, ".busyD"}, 32'(m_busy), 32'd0);
      chk({tag, ".reqD"},  32'(dmem_req), 32'd0);
      chk({tag, ".mstatD"}, 32'(m_stat), 32'(es));
      if (!tmo) chk({tag, ".mvalM"}, m_valM, rdata);
      @(posedge clk); #1;
      if (s < stalls) check_w_bubble({tag, ".held"});
      else check_w(tag, es, icode, valE, rdata, !tmo, err_eff ? RNONE : dE, err_eff ? RNONE : dM);
    end
    W_stall = 1'b0;
    dmem_ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] ic, st;
    logic [31:0] ve, va;
    int unsigned lat;

    reset = 1'b0; M_stat = ST_OK; M_icode = C_NOP; M_dstE = RNONE; M_dstM = RNONE;
    M_valE = '0; M_valA = '0; W_stall = 1'b0; W_bubble = 1'b0;
    dmem_ack = 1'b1; dmem_err = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.req",   32'(dmem_req), 32'd0);
    chk("rst.we",    32'(dmem_we), 32'd0);
    chk("rst.addr",  dmem_addr, 32'd0);
    chk("rst.wdata", dmem_wdata, 32'd0);
    chk("rst.busy",  32'(m_busy), 32'd0);
    check_w_bubble("rst");
    reset = 1'b1;
    @(posedge clk); #1;
    chk("stale.busy", 32'(m_busy), 32'd0);
    chk("stale.valM", m_valM, 32'd0);
    dmem_ack = 1'b0;

    run_instr("mrmovl", C_MRMOVL, ST_OK, 32'h100, 32'h0, 4'h1, 4'h2, 1, 1'b0, 32'hDEAD_BEEF, 0);
    run_instr("pushl", C_PUSHL, ST_OK, 32'h0FFC, 32'h1234, 4'h4, RNONE, 3, 1'b0, 32'h0, 0);
    run_instr("rmmovl_oob", C_RMMOVL, ST_OK, 32'h1000, 32'h77, RNONE, RNONE, 1, 1'b0, 32'h0, 0);
    run_instr("popl_oob", C_POPL, ST_OK, 32'h4, 32'h0FFD, 4'h4, 4'h3, 1, 1'b0, 32'h0, 0);
    run_instr("timeout", C_MRMOVL, ST_OK, 32'h200, 32'h0, RNONE, 4'h6, 0, 1'b0, 32'h0, 1);
    run_instr("stall3", C_MRMOVL, ST_OK, 32'h300, 32'h0, RNONE, 4'h7, 2, 1'b0, 32'hCAFE_F00D, 3);
    run_instr("buserr", C_RET, ST_OK, 32'h0, 32'h40, RNONE, RNONE, 1, 1'b1, 32'h11, 0);
    run_instr("hlt_pass", C_MRMOVL, ST_HLT, 32'h5000, 32'h0, 4'h2, 4'h3, 1, 1'b0, 32'h0, 0);

    // Reset while a request is outstanding.
    M_icode = C_MRMOVL; M_stat = ST_OK; M_valE = 32'h80; M_valA = '0; M_dstE = RNONE; M_dstM = 4'h1;
    @(posedge clk); #1;
    chk("rstreq.inreq", 32'(dmem_req), 32'd1);
    reset = 1'b0; dmem_ack = 1'b1; dmem_rdata = 32'h1234_5678;
    @(posedge clk); #1;
    chk("rstreq.req", 32'(dmem_req), 32'd0);
    check_w_bubble("rstreq");
    M_icode = C_NOP; M_dstM = RNONE; reset = 1'b1;
    #1;
    chk("rstreq.busy", 32'(m_busy), 32'd0);
    @(posedge clk); #1;
    chk("rstreq.nodone", m_valM, 32'd0);
    chk("rstreq.req2", 32'(dmem_req), 32'd0);
    dmem_ack = 1'b0;

    // W hold under stall, then bubble beats stall.
    run_instr("opl", C_OPL, ST_OK, 32'h55, 32'h0, 4'h3, RNONE, 1, 1'b0, 32'h0, 0);
    M_valE = 32'h66; W_stall = 1'b1;
    @(posedge clk); #1;
    check_w("whold", ST_OK, C_OPL, 32'h55, 32'd0, 1'b1, 4'h3, RNONE);
    W_bubble = 1'b1;
    @(posedge clk); #1;
    check_w_bubble("bubwins");
    W_stall = 1'b0; W_bubble = 1'b0;

    for (int i = 0; i < 30; i++) begin
      ic = 4'($urandom_range(0, 11));
      st = ($urandom_range(0, 9) == 0) ? ST_INS : ST_OK;
      ve = ($urandom_range(0, 3) == 0) ? 32'h0FF8 + $urandom_range(0, 12) : $urandom_range(0, 32'h0FFC);
      va = ($urandom_range(0, 3) == 0) ? 32'h0FF8 + $urandom_range(0, 12) : $urandom_range(0, 32'h0FFC);
      lat = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 4);
      run_instr("rand", ic, st, ve, va, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                lat, ($urandom_range(0, 7) == 0), $urandom, $urandom_range(0, 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/y86_mem_stage.md
Name: y86_mem_stage

Overview:
- Memory stage of the 5-stage Y86 pipeline. Consumes the M pipeline register outputs and performs the data-memory access over a req/ack bus.
- Computes m_stat and m_valM, and holds the W pipeline register feeding write-back.
- Raises m_busy so the hazard unit stalls F/D/E/M while a multi-cycle access is outstanding.

Parameters:
- MEM_BYTES, 32'h0000_1000, size of the data address space; an access with addr > MEM_BYTES-4 is an address error.
- TIMEOUT, 16, maximum cycles in REQ waiting for dmem_ack before declaring S_ADR; 0 disables the timeout.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- M_stat, M_icode, M_dstE, M_dstM  in  4 each  M register outputs
- M_valE, M_valA  in  32 each  M register outputs
- W_stall, W_bubble  in  1 each  hazard-unit controls for the W register
- dmem_ack  in  1  access complete
- dmem_err  in  1  bus error, valid with ack
- dmem_rdata  in  32  read data, valid with ack
- dmem_req  out  1  access request
- dmem_we  out  1  1 = write
- dmem_addr  out  32  byte address
- dmem_wdata  out  32  write data
- m_busy  out  1  stall request to hazard unit
- m_stat  out  4  stage status, to hazard unit
- m_valM  out  32  value forwarded to decode
- Wout_stat, Wout_icode, Wout_dstE, Wout_dstM  out  4 each  W register outputs
- Wout_valE, Wout_valM  out  32 each  W register outputs

Behaviour:
- Access classification:
  - Read: I_MRMOVL, I_POPL, I_RET.
  - Write: I_RMMOVL, I_PUSHL, I_CALL.
  - Address: M_valA for POPL/RET, otherwise M_valE. Write data is M_valA.
- need_mem = access icode and M_stat==S_OK.
- range_err = need_mem and addr > MEM_BYTES-4. No bus cycle is issued on range_err.
- FSM states IDLE, REQ, DONE:
  - IDLE: if need_mem and !range_err, go to REQ (load timeout counter); otherwise stay in IDLE.
  - REQ: dmem_req=1, with addr, we and wdata driven from the M register (which is stable because M is stalled).
    - On dmem_ack: capture rdata into hold_valM and dmem_err into hold_err, then go to DONE.
    - On counter expiry (TIMEOUT>0): set hold_err=1, go to DONE.
  - DONE: result valid. Go to IDLE when W_stall==0; otherwise stay and keep hold_valM/hold_err.
- m_busy = (IDLE and need_mem and !range_err) or REQ. m_busy is 0 in DONE.
- Minimum access cost is 2 stall cycles (ack in the first REQ cycle). The instruction leaves M at the clock edge ending DONE.
- dmem_ack is ignored in IDLE and DONE. A stale ack after reset has no effect.
- m_valM = hold_valM in DONE, otherwise 0.
- m_stat = S_ADR if range_err or (DONE and hold_err), otherwise M_stat.
- W register update, in precedence order:
  1. reset==0: icode=I_NOP, stat=S_OK, dstE=dstM=R_NONE, valE=valM=0.
  2. W_bubble: same values as reset.
  3. W_stall: hold.
  4. m_busy: load the bubble values (the stage self-bubbles W).
  5. Otherwise: load m_stat, M_icode, M_valE, m_valM, M_dstE, M_dstM.
- If m_stat==S_ADR, dstE and dstM load R_NONE. The write is not committed to dmem for the faulting instruction only when range_err.
- Reset values: dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0, m_busy=0, FSM=IDLE, counter=0.
- Reset asserted mid-REQ: the request is dropped the next cycle and no DONE is produced.
- M_stat not S_OK: no access is made; the instruction passes straight through.

Decomposition:
- Shared package (y86_define.v): icode, stat and register constants; add S_ADR if absent. Add FSM state encodings MS_IDLE, MS_REQ, MS_DONE.
- One natural sub-module: y86_regW, the W pipeline register with stall/bubble, mirroring the M register style but with synchronous reset. The FSM and address logic stay in y86_mem_stage.

Test Plan:
- MRMOVL, M_valE=0x100, ack on first REQ cycle with rdata=0xDEADBEEF -> m_busy high 2 cycles; Wout_valM=0xDEADBEEF, Wout_stat=S_OK, Wout_dstM=M_dstM.
- PUSHL, M_valE=0x0FFC, M_valA=0x1234 -> dmem_we=1, addr=0x0FFC, wdata=0x1234; ack after 3 cycles -> busy for 4 cycles, then W loads.
- RMMOVL to 0x1000 (MEM_BYTES=0x1000) -> no dmem_req, m_busy=0, m_stat=S_ADR, Wout_stat=S_ADR next edge.
- MRMOVL with no ack for TIMEOUT=16 cycles -> DONE with m_stat=S_ADR; a late ack is ignored.
- DONE with W_stall=1 for 3 cycles -> m_valM held; W unchanged until W_stall drops, then loads once.
- Reset pulled low in REQ -> next cycle dmem_req=0 and W holds NOP/S_OK/R_NONE. Same cycle W_bubble and W_stall -> bubble wins.
